int_async_crossing_source: RTL

- Transmit end of the asynchronous interrupt crossing. Sits in the interrupt-producer clock domain and drives the sync wires that the sink-side synchronizer chain samples.
- Level-type channels are registered glitch-free, so no combinational logic reaches the crossing.
- Pulse-type channels use a 4-phase req/ack handshake, so single-cycle events survive any sink clock ratio.

---
 rtl/int_crossing_pkg.sv | 21 ++
 rtl/int_async_pulse_chan.sv | 103 ++++++++++
 rtl/int_async_crossing_source.sv | 66 ++++++
 3 files changed

// File: rtl/int_crossing_pkg.sv
// Shared types and constants for the asynchronous interrupt crossing (source side).
package int_crossing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } int_state_e;

  localparam int OVF_CNT_W      = 8;
  localparam int SYNC_DEPTH_MIN = 2;
  localparam int SYNC_DEPTH_MAX = 4;

  // Keeps the ack synchronizer inside its supported depth range.
  function automatic int clamp_sync_depth(input int depth);
    if (depth < SYNC_DEPTH_MIN) return SYNC_DEPTH_MIN;
    if (depth > SYNC_DEPTH_MAX) return SYNC_DEPTH_MAX;
    return depth;
  endfunction

endpackage

// File: rtl/int_async_pulse_chan.sv
// One pulse-type interrupt channel: edge detect, ack synchronizer, 4-phase req/ack FSM,
// one-deep pending flag. Optional drop counter when INT_ASYNC_SOURCE_OVF_CNT_EN is defined.
module int_async_pulse_chan
  import int_crossing_pkg::*;
#(
  parameter int SYNC_DEPTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 int_in,
  input  logic                 ack_async_in,
`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
`endif
  output logic                 auto_out_sync,
  output logic                 busy
);

  localparam int SYNC_D = clamp_sync_depth(SYNC_DEPTH);

  int_state_e        state, state_nxt;
  logic              pending, pending_nxt;
  logic              int_in_p1;
  logic [SYNC_D-1:0] ack_sync;
  logic              evt;
  logic              ack_s;
  logic              drop;

  assign evt   = int_in & ~int_in_p1;
  assign ack_s = ack_sync[SYNC_D-1];
  // pending is only ever set outside IDLE, so this is the coalesced-event condition.
  assign drop  = evt & pending;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (evt) state_nxt = REQ;
      end
      REQ: begin
        if (ack_s) state_nxt = DROP;
        if (evt && !pending) pending_nxt = 1'b1;
      end
      DROP: begin
        if (!ack_s) begin
          if (pending || evt) begin
            state_nxt   = REQ;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (evt && !pending) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so the crossing wire is glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      int_in_p1     <= 1'b0;
      ack_sync      <= '0;
      auto_out_sync <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      int_in_p1     <= int_in;
      ack_sync      <= {ack_sync[SYNC_D-2:0], ack_async_in};
      auto_out_sync <= (state_nxt == REQ);
      busy          <= (state_nxt != IDLE) | pending_nxt;
    end
  end

`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: rtl/int_async_crossing_source.sv
// Source (producer-domain) end of the asynchronous interrupt crossing.
// Define INT_ASYNC_SOURCE_OVF_CNT_EN to add per-channel dropped-event counters.
module int_async_crossing_source
  import int_crossing_pkg::*;
#(
  parameter int                 NUM_INT    = 1,
  parameter logic [NUM_INT-1:0] PULSE_MASK = {NUM_INT{1'b0}},
  parameter int                 SYNC_DEPTH = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_INT-1:0]             int_in,
  input  logic [NUM_INT-1:0]             ack_async_in,
`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
  input  logic                           ovf_clr,
  output logic [OVF_CNT_W*NUM_INT-1:0]   ovf_cnt,
`endif
  output logic [NUM_INT-1:0]             auto_out_sync,
  output logic [NUM_INT-1:0]             busy
);

`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
  logic unused_clr;
  assign unused_clr = ovf_clr;
`endif

  for (genvar i = 0; i < NUM_INT; i++) begin : g_chan
    logic out_bit;
    logic busy_bit;

    if (PULSE_MASK[i]) begin : g_pulse
      int_async_pulse_chan #(
        .SYNC_DEPTH (SYNC_DEPTH)
      ) u_chan (
        .clock         (clock),
        .reset         (reset),
        .int_in        (int_in[i]),
        .ack_async_in  (ack_async_in[i]),
`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
        .ovf_clr       (ovf_clr),
        .ovf_cnt       (ovf_cnt[i*OVF_CNT_W +: OVF_CNT_W]),
`endif
        .auto_out_sync (out_bit),
        .busy          (busy_bit)
      );
    end else begin : g_level
      // Level channels never handshake; the ack wire is intentionally ignored.
      logic unused_ack;
      assign unused_ack = ack_async_in[i];
      assign busy_bit   = 1'b0;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) out_bit <= 1'b0;
        else        out_bit <= int_in[i];
      end

`ifdef INT_ASYNC_SOURCE_OVF_CNT_EN
      assign ovf_cnt[i*OVF_CNT_W +: OVF_CNT_W] = '0;
`endif
    end

    assign auto_out_sync[i] = out_bit;
    assign busy[i]          = busy_bit;
  end

endmodule
